// File: rtl/cpu_pkg.sv
// Shared fetch-path types.
//   fetch_entry_t : one queued instruction together with its fetch PC
//   INSTR_BYTES   : PC stride between sequential instructions
package cpu_pkg;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch_entry_t with DEPTH entries, first-word fall-through.
// Ports:
//   clk, reset (async, active low)
//   push/push_data : write one entry at the tail
//   pop            : drop the head entry
//   flush          : empty the buffer; overrides same-cycle push and pop
//   count          : number of valid entries (0..DEPTH)
//   head           : oldest entry, all-zero when empty
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_data,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the wrap mod DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    (push && !flush && !pop) |-> (count != (AW+1)'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    (pop && !flush) |-> (count != '0));
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues sequential in-order imem requests,
// queues returned words with their PCs and hands them to ID (valid/ready).
// A redirect from EX flushes the queue and discards responses still in flight.
// Ports:
//   clk, reset (async, active low)
//   imem_req_valid/ready/addr : fetch request channel
//   imem_rsp_valid/data       : in-order instruction return
//   redirect_valid/pc         : taken branch, refetch from redirect_pc & ~3
//   id_valid/ready/pc/instr   : head of queue toward decode
// Optional build macro FETCH_PERF_EN adds perf_bubble_cnt / perf_flush_cnt.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [63:0]  fetch_pc, rsp_pc, redir_pc;
  logic [CW-1:0] outst, drop_cnt, count;
  logic [CW:0]  inflight;
  logic         req_fire, push, pop;
  fetch_entry_t head, push_entry;

  assign redir_pc = redirect_pc & ~64'h3;

  // Credits cover queued plus in-flight words, so a response always has room.
  assign inflight       = {1'b0, count} + {1'b0, outst};
  assign imem_req_valid = reset && !redirect_valid
                        && (inflight < (CW+1)'(DEPTH))
                        && (outst < CW'(MAX_OUTST));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Redirect voids both ends of the queue in its cycle.
  assign push       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop        = id_valid && id_ready && !redirect_valid;
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .count     (count),
    .head      (head)
  );

  assign id_valid = (count != '0);
  assign id_pc    = head.pc;
  assign id_instr = head.instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outst - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'(INSTR_BYTES);
        if (push)     rsp_pc   <= rsp_pc + 64'(INSTR_BYTES);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (id_ready && !id_valid && (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  a_rsp_outst: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outst != '0));
  a_drop_le_outst: assert property (@(posedge clk) disable iff (!reset)
    drop_cnt <= outst);
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: an imem model answers accepted
// requests in order; every accepted request on the current path is expected
// at ID in order, and a redirect voids all expectations from the old path.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_flush_cnt;
  longint      exp_bub, exp_fl;
`endif

  if_fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] pend[$];
  logic [63:0] model_pc;
  int checks = 0, errors = 0, pops = 0;
  int req_prob, rsp_prob, rdy_prob;

  function automatic logic [31:0] word_of(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Request side of the scoreboard and imem bookkeeping.
  always @(negedge clk) begin
    if (reset) begin
`ifdef FETCH_PERF_EN
      if (id_ready && !id_valid) exp_bub++;
      if (redirect_valid) exp_fl++;
`endif
      if (imem_rsp_valid) void'(pend.pop_front());
      if (redirect_valid) begin
        chk("no_req_on_redirect", {63'd0, imem_req_valid}, 64'd0);
        exp_q.delete();
        model_pc = redirect_pc & ~64'h3;
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        pend.push_back(imem_req_addr);
        exp_q.push_back('{pc: model_pc, instr: word_of(model_pc)});
        model_pc = model_pc + 64'd4;
      end
    end
  end

  // Monitor: compares whatever ID consumes against the expectation queue.
  always @(negedge clk) begin
    if (reset && id_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("id_unexpected_pc", id_pc, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_instr", {32'd0, id_instr}, {32'd0, e.instr});
        pops++;
      end
    end
    if (reset && !id_valid)
      chk("id_zero_when_empty", id_pc | {32'd0, id_instr}, 64'd0);
  end

  task automatic drive_rsp(bit en);
    if (en && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    imem_req_ready = ($urandom_range(99) < req_prob);
    id_ready       = ($urandom_range(99) < rdy_prob);
    drive_rsp($urandom_range(99) < rsp_prob);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_redirect(logic [63:0] pc, bit rsp_en);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    drive_rsp(rsp_en);
  endtask

  task automatic set_rates(int rq, int rs, int rd);
    req_prob = rq; rsp_prob = rs; rdy_prob = rd;
  endtask

  initial begin
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    model_pc = 64'h0;
`ifdef FETCH_PERF_EN
    exp_bub = 0; exp_fl = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Streaming at full rate.
    set_rates(100, 100, 100);
    run(20);

    // ID stalled: queue fills, requests stop.
    set_rates(100, 100, 0);
    run(12);
    @(negedge clk);
    chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("stall_id_valid", {63'd0, id_valid}, 64'd1);
    set_rates(100, 100, 100);
    run(10);

    // Two requests in flight, then redirect to an unaligned target.
    set_rates(100, 0, 100);
    run(4);
    chk("two_in_flight", pend.size(), 2);
    do_redirect(64'h203, 1'b0);
    set_rates(100, 100, 100);
    run(12);

    // Redirect with a same-cycle response and pop.
    set_rates(100, 100, 0);
    run(3);
    do_redirect(64'h1000, 1'b1);
    set_rates(100, 100, 100);
    cycle();
    @(negedge clk);
    chk("redirect_flush_empty", {63'd0, id_valid}, 64'd0);
    run(10);

    // Top-of-address-space wrap.
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    run(16);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(39) == 0) begin
        do_redirect({$urandom, $urandom}, $urandom_range(1) == 1);
        set_rates($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(10, 100));
      end else begin
        cycle();
      end
    end

    // Reset mid-stream with entries queued.
    set_rates(100, 100, 0);
    run(8);
    @(posedge clk); #1;
    reset = 1'b0;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    pend.delete(); exp_q.delete(); model_pc = 64'h0;
    #1;
    chk("midrst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("midrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
`ifdef FETCH_PERF_EN
    exp_bub = 0; exp_fl = 0;
    chk("midrst_perf_bubble", {32'd0, perf_bubble_cnt}, 64'd0);
    chk("midrst_perf_flush", {32'd0, perf_flush_cnt}, 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    set_rates(100, 100, 100);
    run(20);

    // Drain: stop new requests and let everything reach ID.
    set_rates(0, 100, 100);
    for (int i = 0; i < 300 && (exp_q.size() > 0 || pend.size() > 0); i++) cycle();
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
    id_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    chk("perf_bubble", {32'd0, perf_bubble_cnt}, exp_bub);
    chk("perf_flush", {32'd0, perf_flush_cnt}, exp_fl);
`endif
    checks++;
    if (pops < 100) begin
      errors++;
      $display("FAIL stream_progress got %0d want >=100", pops);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
